// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler: sequences the decoded slot pair onto issue lanes, splits hazardous pairs, serializes CSR/system/AMO.
// Optional perf counters (split_cnt, serial_cnt) are built only when SCHED_PERF_CNT_EN is defined.
module dual_issue_scheduler #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_PORTS      = 1,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [1:0]                     d_valid,
  input  logic [1:0]                     d_uses_rd,
  input  logic [1:0][REG_ADDR_WIDTH-1:0] d_rd,
  input  logic [1:0]                     d_uses_rs1,
  input  logic [1:0]                     d_uses_rs2,
  input  logic [1:0][REG_ADDR_WIDTH-1:0] d_rs1,
  input  logic [1:0][REG_ADDR_WIDTH-1:0] d_rs2,
  input  logic [1:0]                     d_is_mem,
  input  logic [1:0]                     d_serial,
  input  logic                           issue_ready,
  input  logic                           pipe_empty,
  output logic [1:0]                     issue_valid,
  output logic                           lane0_sel,
  output logic                           decode_stall
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]           split_cnt,
  output logic [CNT_WIDTH-1:0]           serial_cnt
`endif
);

  typedef enum logic [1:0] {PAIR, SECOND, DRAIN} state_e;

  state_e state_q, state_d;
  logic   pend1_q, pend1_d;
  logic   drain_arm_q, drain_arm_d;
  logic   raw_hz, waw_hz, mem_hz, ser_hz, conflict;
  logic   lone_ser;
  logic   split_inc, serial_inc;

  // x0 is never a real destination, so it can never create a RAW or WAW hazard.
  always_comb begin
    raw_hz   = d_uses_rd[0] && (d_rd[0] != '0) &&
               ((d_uses_rs1[1] && (d_rs1[1] == d_rd[0])) ||
                (d_uses_rs2[1] && (d_rs2[1] == d_rd[0])));
    waw_hz   = (&d_uses_rd) && (d_rd[0] == d_rd[1]) && (d_rd[0] != '0);
    mem_hz   = (MEM_PORTS == 1) && (&d_is_mem);
    ser_hz   = |d_serial;
    conflict = raw_hz || waw_hz || mem_hz || ser_hz;
    lone_ser = d_valid[0] ? d_serial[0] : d_serial[1];
  end

  always_comb begin
    issue_valid  = 2'b00;
    lane0_sel    = 1'b0;
    decode_stall = 1'b0;
    state_d      = state_q;
    pend1_d      = pend1_q;
    drain_arm_d  = 1'b0;
    split_inc    = 1'b0;
    serial_inc   = 1'b0;
    if (reset || flush) begin
      state_d = PAIR;
      pend1_d = 1'b0;
    end else begin
      case (state_q)
        PAIR: begin
          if ((d_valid == 2'b11) && conflict) begin
            issue_valid  = 2'b01;
            decode_stall = 1'b1;
            if (issue_ready) begin
              split_inc  = 1'b1;
              serial_inc = d_serial[0];
              if (d_serial[0]) begin
                state_d     = DRAIN;
                pend1_d     = 1'b1;
                drain_arm_d = 1'b1;
              end else begin
                state_d = SECOND;
              end
            end
          end else if (d_valid == 2'b11) begin
            issue_valid  = 2'b11;
            decode_stall = !issue_ready;
          end else if (d_valid != 2'b00) begin
            issue_valid  = 2'b01;
            lane0_sel    = !d_valid[0];
            decode_stall = !issue_ready;
            if (issue_ready && lone_ser) begin
              serial_inc  = 1'b1;
              state_d     = DRAIN;
              pend1_d     = 1'b0;
              drain_arm_d = 1'b1;
            end
          end
        end
        SECOND: begin
          issue_valid  = 2'b01;
          lane0_sel    = 1'b1;
          decode_stall = !issue_ready;
          if (issue_ready) begin
            serial_inc  = d_serial[1];
            pend1_d     = 1'b0;
            state_d     = d_serial[1] ? DRAIN : PAIR;
            drain_arm_d = d_serial[1];
          end
        end
        DRAIN: begin
          decode_stall = 1'b1;
          // The serializing op issued last cycle may not be visible to pipe_empty yet.
          if (!drain_arm_q && pipe_empty) begin
            state_d = pend1_q ? SECOND : PAIR;
            pend1_d = 1'b0;
          end
        end
        default: begin
          state_d = PAIR;
          pend1_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PAIR;
      pend1_q     <= 1'b0;
      drain_arm_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend1_q     <= pend1_d;
      drain_arm_q <= drain_arm_d;
    end
  end

`ifdef SCHED_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] split_cnt_q, serial_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      split_cnt_q  <= '0;
      serial_cnt_q <= '0;
    end else begin
      if (split_inc && !(&split_cnt_q)) split_cnt_q <= split_cnt_q + 1'b1;
      if (serial_inc && !(&serial_cnt_q)) serial_cnt_q <= serial_cnt_q + 1'b1;
    end
  end

  assign split_cnt  = split_cnt_q;
  assign serial_cnt = serial_cnt_q;
`else
  logic [CNT_WIDTH-1:0] unused_cnt_w;
  assign unused_cnt_w = {CNT_WIDTH{split_inc ^ serial_inc}};
`endif

endmodule
